// File: rtl/regfile_sb.sv
// regfile_sb: dual-write-port register file with write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter bit BYPASS    = 1,
  parameter bit ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_SEL-1:0]   rs1,
  output logic [WORD_SIZE-1:0] rs1Data,
  output logic                 rs1Busy,
  input  logic [REG_SEL-1:0]   rs2,
  output logic [WORD_SIZE-1:0] rs2Data,
  output logic                 rs2Busy,
  input  logic                 wCtrl0,
  input  logic [REG_SEL-1:0]   wSel0,
  input  logic [WORD_SIZE-1:0] wData0,
  input  logic                 wCtrl1,
  input  logic [REG_SEL-1:0]   wSel1,
  input  logic [WORD_SIZE-1:0] wData1,
  input  logic                 iss,
  input  logic [REG_SEL-1:0]   issRd,
  input  logic                 flush,
  output logic [REG_SEL:0]     busyCnt
);
  localparam int CW = REG_SEL + 1;
  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy, set_v, clr_v, busy_nxt;
  logic [CW-1:0] cnt_nxt;
  logic set_new, d0, d1;
  logic [REG_SEL-1:0] rs [2];
  logic [WORD_SIZE-1:0] rd [2];
  logic rb [2];
  assign rs[0] = rs1;
  assign rs[1] = rs2;
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss && !(ZERO_REG && issRd == '0)) set_v[issRd] = 1'b1;
    if (wCtrl0) clr_v[wSel0] = 1'b1;
    if (wCtrl1) clr_v[wSel1] = 1'b1;
  end
  // Count only transitions: a set on a busy bit is a no-op, a clear losing to a set is ignored.
  assign set_new  = |(set_v & ~busy);
  assign d0       = wCtrl0 && busy[wSel0] && !set_v[wSel0];
  assign d1       = wCtrl1 && busy[wSel1] && !set_v[wSel1] && !(wCtrl0 && wSel0 == wSel1);
  assign busy_nxt = flush ? '0 : (busy & ~clr_v) | set_v;
  assign cnt_nxt  = flush ? '0 : busyCnt + CW'(set_new) - CW'(d0) - CW'(d1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy    <= '0;
      busyCnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (!(ZERO_REG && i == 0)) begin
          if (wCtrl1 && wSel1 == REG_SEL'(i)) regs[i] <= wData1;
          else if (wCtrl0 && wSel0 == REG_SEL'(i)) regs[i] <= wData0;
        end
      busy    <= busy_nxt;
      busyCnt <= cnt_nxt;
    end
  end
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit0, hit1, zr;
    assign hit1  = BYPASS && wCtrl1 && wSel1 == rs[p];
    assign hit0  = BYPASS && wCtrl0 && wSel0 == rs[p];
    assign zr    = ZERO_REG && rs[p] == '0;
    assign rd[p] = zr ? '0 : hit1 ? wData1 : hit0 ? wData0 : regs[rs[p]];
    assign rb[p] = !zr && busy[rs[p]] && !hit1 && !hit0;
  end
  assign rs1Data = rd[0];
  assign rs2Data = rd[1];
  assign rs1Busy = rb[0];
  assign rs2Busy = rb[1];
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of a bypassing and a non-bypassing regfile_sb driven in lockstep.
module tb_regfile_sb;
  logic clk = 0, rst = 0;
  logic [4:0] rs1 = 0, rs2 = 0, wSel0 = 0, wSel1 = 0, issRd = 0;
  logic wCtrl0 = 0, wCtrl1 = 0, iss = 0, flush = 0;
  logic [31:0] wData0 = 0, wData1 = 0;
  logic [31:0] rs1Data, rs2Data, nb_rs1Data, nb_rs2Data;
  logic rs1Busy, rs2Busy, nb_rs1Busy, nb_rs2Busy;
  logic [5:0] busyCnt, nb_busyCnt;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  regfile_sb dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs1Data(rs1Data), .rs1Busy(rs1Busy),
    .rs2(rs2), .rs2Data(rs2Data), .rs2Busy(rs2Busy),
    .wCtrl0(wCtrl0), .wSel0(wSel0), .wData0(wData0),
    .wCtrl1(wCtrl1), .wSel1(wSel1), .wData1(wData1),
    .iss(iss), .issRd(issRd), .flush(flush), .busyCnt(busyCnt)
  );
  regfile_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rs1(rs1), .rs1Data(nb_rs1Data), .rs1Busy(nb_rs1Busy),
    .rs2(rs2), .rs2Data(nb_rs2Data), .rs2Busy(nb_rs2Busy),
    .wCtrl0(wCtrl0), .wSel0(wSel0), .wData0(wData0),
    .wCtrl1(wCtrl1), .wSel1(wSel1), .wData1(wData1),
    .iss(iss), .issRd(issRd), .flush(flush), .busyCnt(nb_busyCnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  task automatic idle;
    wCtrl0 = 0; wCtrl1 = 0; iss = 0; flush = 0;
  endtask
  task automatic issue(input logic [4:0] r);
    iss = 1; issRd = r; cyc; idle;
  endtask
  initial begin
    rs1 = 5;
    #1 check("reset_cnt", busyCnt, 0);
    check("reset_rd", rs1Data, 0);
    cyc; rst = 1;
    wCtrl0 = 1; wSel0 = 5; wData0 = 32'hDEADBEEF;
    #1 check("byp_wr5", rs1Data, 32'hDEADBEEF);
    check("nb_wr5_old", nb_rs1Data, 0);
    cyc; idle;
    #1 check("stored5", nb_rs1Data, 32'hDEADBEEF);
    #2 rst = 0;
    #1 check("async_rst5", rs1Data, 0);
    check("async_rst5_nb", nb_rs1Data, 0);
    cyc; rst = 1;
    wCtrl0 = 1; wSel0 = 5; wData0 = 32'h12345678;
    cyc; idle;
    #1 check("rewr5", nb_rs1Data, 32'h12345678);
    // zero register
    wCtrl0 = 1; wSel0 = 0; wData0 = 32'hFFFFFFFF; iss = 1; issRd = 0; rs1 = 0;
    #1 check("zero_byp", rs1Data, 0);
    check("zero_busy_now", rs1Busy, 0);
    cyc; idle;
    #1 check("zero_rd", nb_rs1Data, 0);
    check("zero_busy", rs1Busy, 0);
    check("zero_cnt", busyCnt, 0);
    // dual-write conflict
    rs2 = 7;
    wCtrl0 = 1; wSel0 = 7; wData0 = 32'hAAAA0000;
    wCtrl1 = 1; wSel1 = 7; wData1 = 32'h0000BBBB;
    #1 check("conf_byp", rs2Data, 32'h0000BBBB);
    check("conf_nb_old", nb_rs2Data, 0);
    cyc; idle;
    #1 check("conf_stored", rs2Data, 32'h0000BBBB);
    check("conf_stored_nb", nb_rs2Data, 32'h0000BBBB);
    // port 0 alone bypasses when port 1 targets elsewhere
    wCtrl0 = 1; wSel0 = 7; wData0 = 32'h0BAD0BAD; wCtrl1 = 1; wSel1 = 8; wData1 = 32'h1;
    #1 check("byp_p0", rs2Data, 32'h0BAD0BAD);
    cyc; idle;
    // load-use
    rs1 = 9; iss = 1; issRd = 9;
    #1 check("lu_pre", rs1Busy, 0);
    cyc; idle;
    #1 check("lu_busy", rs1Busy, 1);
    check("lu_cnt", busyCnt, 1);
    wCtrl1 = 1; wSel1 = 9; wData1 = 32'h55;
    #1 check("lu_mask", rs1Busy, 0);
    check("lu_nomask_nb", nb_rs1Busy, 1);
    check("lu_data", rs1Data, 32'h55);
    cyc; idle;
    #1 check("lu_clr", rs1Busy, 0);
    check("lu_cnt0", busyCnt, 0);
    // set versus clear
    rs2 = 3;
    issue(3);
    #1 check("svc_cnt1", busyCnt, 1);
    iss = 1; issRd = 3; wCtrl0 = 1; wSel0 = 3; wData0 = 32'h3;
    cyc; idle;
    #1 check("svc_busy", rs2Busy, 1);
    check("svc_cnt", busyCnt, 1);
    wCtrl0 = 1; wSel0 = 3;
    cyc; idle;
    #1 check("svc_clr_cnt", busyCnt, 0);
    // double clear of two distinct busy registers
    issue(10);
    issue(11);
    #1 check("dbl_cnt2", busyCnt, 2);
    wCtrl0 = 1; wSel0 = 10; wCtrl1 = 1; wSel1 = 11;
    cyc; idle;
    #1 check("dbl_cnt0", busyCnt, 0);
    // clearing a non-busy register
    wCtrl0 = 1; wSel0 = 12;
    cyc; idle;
    #1 check("clr_idle_cnt", busyCnt, 0);
    // flush
    issue(1);
    issue(2);
    issue(4);
    #1 check("fl_cnt3", busyCnt, 3);
    check("fl_cnt3_nb", nb_busyCnt, 3);
    flush = 1; iss = 1; issRd = 6;
    cyc; idle;
    rs1 = 6; rs2 = 4;
    #1 check("fl_cnt0", busyCnt, 0);
    check("fl_b6", rs1Busy, 0);
    check("fl_b4", nb_rs2Busy, 0);
    // reset clears the scoreboard
    issue(8);
    rs1 = 8;
    #1 check("rst_pre_busy", rs1Busy, 1);
    #2 rst = 0;
    #1 check("rst_cnt", busyCnt, 0);
    check("rst_busy", rs1Busy, 0);
    cyc; rst = 1;
    cyc;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write-port register file: two write ports (ALU writeback port 0, load writeback port 1), two combinational read ports, optional write-to-read bypass, and a per-register busy scoreboard.
- Sits between decode/issue and the execute and memory writeback stages.
- Issue sets a register pending; writeback clears it. Decode uses the busy outputs to raise load-use and multi-cycle stalls.

Parameters:
- WORD_SIZE, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers. Must be a power of two and at least 2.
- REG_SEL, $clog2(NUM_REGS), register select width.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads return stored values only.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and is never busy; 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rs1  input  REG_SEL  read port 1 select.
- rs1Data  output  WORD_SIZE  read port 1 data.
- rs1Busy  output  1  read port 1 source is pending.
- rs2  input  REG_SEL  read port 2 select.
- rs2Data  output  WORD_SIZE  read port 2 data.
- rs2Busy  output  1  read port 2 source is pending.
- wCtrl0  input  1  write port 0 enable (ALU).
- wSel0  input  REG_SEL  write port 0 destination.
- wData0  input  WORD_SIZE  write port 0 data.
- wCtrl1  input  1  write port 1 enable (load).
- wSel1  input  REG_SEL  write port 1 destination.
- wData1  input  WORD_SIZE  write port 1 data.
- iss  input  1  an instruction with a destination register issues this cycle.
- issRd  input  REG_SEL  destination register of the issuing instruction.
- flush  input  1  clears the whole scoreboard (pipeline flush).
- busyCnt  output  REG_SEL+1  number of registers currently busy.

Behaviour:
- Reset: rst low forces all registers to 0, all busy bits to 0 and busyCnt to 0, immediately and without waiting for clk. It takes effect even mid-operation. The first write is accepted on the first rising edge after rst goes high.
- Writes: on the rising edge, reg[wSelN] <= wDataN when wCtrlN is 1. Writes to register 0 are dropped when ZERO_REG=1.
- Write conflict: both ports enabled with the same destination in one cycle -> port 1 data is stored.
- Reads are combinational with zero latency.
  - ZERO_REG=1 and select = 0 -> data 0 and busy 0.
  - BYPASS=1: if a port is writing the selected register this cycle, return that write data. Port 1 takes priority over port 0. Otherwise return the stored value.
  - BYPASS=0: always return the stored value, so the new value is visible the cycle after the write.
- Scoreboard, per register r, evaluated at the rising edge:
  - The bit is set by iss with issRd == r.
  - The bit is cleared by wCtrl0 or wCtrl1 with wSelN == r.
  - Set and clear on the same r in the same cycle -> set wins, because a newer producer has issued.
  - flush = 1 -> all bits are cleared. flush overrides set and clear in that cycle.
  - Register 0 is never set when ZERO_REG=1.
  - Clearing a register that is not busy has no effect.
- Busy outputs: rsNBusy = busy[rsN].
  - When BYPASS=1, rsNBusy is masked to 0 if a write to rsN occurs this cycle, because the data is forwarded.
  - When BYPASS=0, it is not masked.
- busyCnt: a registered count equal to the popcount of the busy vector after the same edge.
  - It is updated incrementally by (+1 if a new bit is set) − (number of bits cleared). This is −2 when the ports write two distinct busy registers.
  - flush sets it to 0.
  - It never exceeds NUM_REGS − ZERO_REG and never wraps.
- No handshake back-pressure: the issuing stage is responsible for not issuing to a busy source.

Test Plan:
- Reset then write: pulse rst low mid-run after writing reg5 = 0xDEADBEEF -> rs1=5 reads 0 immediately while rst is low. Then write reg5 = 0x12345678 via port 0 -> read the next cycle returns 0x12345678.
- Zero register: wCtrl0=1, wSel0=0, wData0=0xFFFFFFFF; iss with issRd=0 -> rs1=0 gives 0 and busy 0, and busyCnt stays 0.
- Dual-write conflict and bypass: same cycle, port 0 writes reg7 = 0xAAAA0000 and port 1 writes reg7 = 0x0000BBBB, with rs2=7 -> rs2Data = 0x0000BBBB in that cycle (BYPASS=1) and it is stored afterwards. With BYPASS=0 the old value is read that cycle.
- Load-use: iss with issRd=9 -> rs1=9 shows busy 1 and busyCnt 1. Then wCtrl1 with wSel1=9 -> rs1Busy is 0 in that cycle (BYPASS=1), the bit is clear the next cycle, and busyCnt returns to 0.
- Set-versus-clear: reg3 is busy; in one cycle iss issRd=3 and wCtrl0 wSel0=3 -> reg3 stays busy and busyCnt is unchanged.
- Flush: set regs 1, 2 and 4 busy (busyCnt=3), then flush together with iss issRd=6 -> all bits are 0 and busyCnt = 0 the next cycle.
